// File: rtl/mod_pkg.sv
// Shared types and constants for the modulation controller and its PRBS source.
package mod_pkg;

  typedef enum logic [1:0] {M_CONST, M_FSK, M_SWEEP, M_RSVD} mod_mode_t;

  localparam int LFSR_W = 5;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 5'b00001;

  // Maximal-length 5-bit Fibonacci step, period 31 from any non-zero state.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[0] ^ s[2], s[LFSR_W-1:1]};
  endfunction

  function automatic logic lfsr_next_bit(input logic [LFSR_W-1:0] s);
    logic [LFSR_W-1:0] n;
    n = lfsr_next(s);
    return n[0];
  endfunction

endpackage

// File: rtl/lfsr5.sv
// 5-bit PRBS generator; clear reseeds and takes priority over step.
module lfsr5
  import mod_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              step_i,
  input  logic              clear_i,
  output logic [LFSR_W-1:0] q_o
);

  logic [LFSR_W-1:0] state_q;
  logic [LFSR_W-1:0] state_d;

  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = LFSR_SEED;
    end else if (step_i) begin
      state_d = lfsr_next(state_q);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= LFSR_SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign q_o = state_q;

endmodule

// File: rtl/mod_phase_ctrl.sv
// Tuning-word controller for the DDS: constant tone, PRBS-driven FSK or linear
// sweep, with a symbol strobe and PRBS bit exported for downstream keying.
module mod_phase_ctrl
  import mod_pkg::*;
#(
  parameter int SYMBOL_DIV = 50_000_000,
  parameter int PW         = 32
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          en_i,
  input  logic          load_i,
  input  logic [1:0]    mode_i,
  input  logic [PW-1:0] f0_inc_i,
  input  logic [PW-1:0] f1_inc_i,
  input  logic [PW-1:0] sweep_step_i,
  output logic [PW-1:0] phase_inc_o,
  output logic          sym_bit_o,
  output logic          sym_strobe_o
);

  localparam int CW = (SYMBOL_DIV > 2) ? $clog2(SYMBOL_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SYMBOL_DIV - 1);

  mod_mode_t     shMode_q, shMode_d;
  logic [PW-1:0] shF0_q, shF0_d;
  logic [PW-1:0] shF1_q, shF1_d;
  logic [PW-1:0] shStep_q, shStep_d;
  logic [CW-1:0] symCnt_q, symCnt_d;
  logic [PW-1:0] acc_q, acc_d;
  logic [PW-1:0] phaseInc_q, phaseInc_d;
  logic          symStrobe_q, symStrobe_d;

  logic              tick;
  logic              nextBit;
  logic [LFSR_W-1:0] lfsrState;
  logic [PW:0]       sweepSum;
  logic [PW-1:0]     sweepNext;

  lfsr5 uLfsr (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .step_i  (tick),
    .clear_i (load_i),
    .q_o     (lfsrState)
  );

  // The sum is one bit wider so a step that overflows PW bits still wraps to f0.
  always_comb begin
    tick      = en_i && !load_i && (symCnt_q == CNT_LAST);
    nextBit   = lfsr_next_bit(lfsrState);
    sweepSum  = {1'b0, acc_q} + {1'b0, shStep_q};
    sweepNext = (sweepSum > {1'b0, shF1_q}) ? shF0_q : sweepSum[PW-1:0];
  end

  always_comb begin
    shMode_d    = shMode_q;
    shF0_d      = shF0_q;
    shF1_d      = shF1_q;
    shStep_d    = shStep_q;
    symCnt_d    = symCnt_q;
    acc_d       = acc_q;
    phaseInc_d  = phaseInc_q;
    symStrobe_d = 1'b0;

    if (load_i) begin
      shMode_d   = mod_mode_t'(mode_i);
      shF0_d     = f0_inc_i;
      shF1_d     = f1_inc_i;
      shStep_d   = sweep_step_i;
      symCnt_d   = '0;
      acc_d      = f0_inc_i;
      // The LFSR restarts at the seed, whose bit is 1, so FSK opens on f1.
      phaseInc_d = (mod_mode_t'(mode_i) == M_FSK) ? f1_inc_i : f0_inc_i;
    end else if (en_i) begin
      if (tick) begin
        symCnt_d    = '0;
        acc_d       = sweepNext;
        symStrobe_d = 1'b1;
        case (shMode_q)
          M_FSK:   phaseInc_d = nextBit ? shF1_q : shF0_q;
          M_SWEEP: phaseInc_d = sweepNext;
          default: phaseInc_d = shF0_q;
        endcase
      end else begin
        symCnt_d = symCnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      shMode_q    <= M_CONST;
      shF0_q      <= '0;
      shF1_q      <= '0;
      shStep_q    <= '0;
      symCnt_q    <= '0;
      acc_q       <= '0;
      phaseInc_q  <= '0;
      symStrobe_q <= 1'b0;
    end else begin
      shMode_q    <= shMode_d;
      shF0_q      <= shF0_d;
      shF1_q      <= shF1_d;
      shStep_q    <= shStep_d;
      symCnt_q    <= symCnt_d;
      acc_q       <= acc_d;
      phaseInc_q  <= phaseInc_d;
      symStrobe_q <= symStrobe_d;
    end
  end

  assign phase_inc_o  = phaseInc_q;
  assign sym_bit_o    = lfsrState[0];
  assign sym_strobe_o = symStrobe_q;

endmodule

// File: tb/tb_mod_phase_ctrl.sv
// Randomized self-checking bench for mod_phase_ctrl with a behavioural model.
module tb_mod_phase_ctrl;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        reset, en, load;
  logic [1:0]  mode;
  logic [31:0] f0, f1, step;
  logic [31:0] phase_inc;
  logic        sym_bit, sym_strobe;

  int checks = 0;
  int errors = 0;

  // Reference model: symbols counted in enabled cycles, PRBS as a table.
  bit          prbs [31];
  int          mEnCnt;
  int          mTicks;
  logic [1:0]  mMode;
  logic [31:0] mF0, mF1, mStep, mAcc, mPhase;
  logic        mBit, mStrobe;

  mod_phase_ctrl #(.SYMBOL_DIV(DIV), .PW(32)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .en_i         (en),
    .load_i       (load),
    .mode_i       (mode),
    .f0_inc_i     (f0),
    .f1_inc_i     (f1),
    .sweep_step_i (step),
    .phase_inc_o  (phase_inc),
    .sym_bit_o    (sym_bit),
    .sym_strobe_o (sym_strobe)
  );

  always #5 clk = ~clk;

  function automatic void buildPrbs();
    int s;
    s = 1;
    for (int k = 0; k < 31; k++) begin
      prbs[k] = bit'(s & 1);
      s = (((s ^ (s >> 2)) & 1) << 4) | (s >> 1);
    end
  endfunction

  function automatic void modelReset();
    mEnCnt = 0; mTicks = 0; mMode = 2'd0;
    mF0 = '0; mF1 = '0; mStep = '0; mAcc = '0;
    mPhase = '0; mBit = 1'b1; mStrobe = 1'b0;
  endfunction

  function automatic void modelEdge();
    logic [32:0] sum;
    if (reset) begin
      modelReset();
    end else if (load) begin
      mMode = mode; mF0 = f0; mF1 = f1; mStep = step; mAcc = f0;
      mEnCnt = 0; mTicks = 0; mBit = 1'b1; mStrobe = 1'b0;
      mPhase = (mode == 2'd1) ? f1 : f0;
    end else if (en) begin
      mEnCnt++;
      mStrobe = 1'b0;
      if (mEnCnt % DIV == 0) begin
        mTicks++;
        mBit = prbs[mTicks % 31];
        sum = {1'b0, mAcc} + {1'b0, mStep};
        mAcc = (sum > {1'b0, mF1}) ? mF0 : sum[31:0];
        if (mMode == 2'd1) mPhase = mBit ? mF1 : mF0;
        else if (mMode == 2'd2) mPhase = mAcc;
        else mPhase = mF0;
        mStrobe = 1'b1;
      end
    end else begin
      mStrobe = 1'b0;
    end
  endfunction

  task automatic stepCycle();
    modelEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic doLoad(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] s);
    mode = m; f0 = a; f1 = b; step = s; en = 1'b1; load = 1'b1;
    stepCycle();
    load = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (phase_inc !== 32'h0 || sym_bit !== 1'b1 || sym_strobe !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_values got %h/%b/%b want 00000000/1/0", phase_inc, sym_bit, sym_strobe);
    end
    stepCycle();
    reset = 1'b0;
    repeat (6) begin
      stepCycle();
      checks++;
      if (phase_inc !== 32'h0 || sym_bit !== 1'b1 || sym_strobe !== 1'b0) begin
        errors++;
        $display("[TB] FAIL idle_after_reset got %h/%b/%b want 00000000/1/0", phase_inc, sym_bit, sym_strobe);
      end
    end
  endtask

  task automatic test_const();
    doLoad(2'd0, 32'h045A1CAC, $urandom, $urandom);
    checks++;
    if (phase_inc !== 32'h045A1CAC) begin
      errors++;
      $display("[TB] FAIL const_load got %h want 045a1cac", phase_inc);
    end
    f0 = $urandom; f1 = $urandom;
    for (int i = 1; i <= 12; i++) begin
      stepCycle();
      checks++;
      if (sym_strobe !== ((i % DIV) == 0) || phase_inc !== 32'h045A1CAC || sym_bit !== mBit) begin
        errors++;
        $display("[TB] FAIL const_run cyc %0d got %h/%b/%b want 045a1cac/%b/%b",
                 i, phase_inc, sym_bit, sym_strobe, mBit, (i % DIV) == 0);
      end
    end
  endtask

  task automatic test_fsk();
    logic [31:0] fa, fb;
    logic [5:0]  expBits;
    int n;
    fa = 32'h045A1CAC; fb = 32'h08B43958; expBits = 6'b100001;
    doLoad(2'd1, fa, fb, $urandom);
    checks++;
    if (sym_bit !== 1'b1 || phase_inc !== fb) begin
      errors++;
      $display("[TB] FAIL fsk_load got %h/%b want %h/1", phase_inc, sym_bit, fb);
    end
    for (int k = 1; k <= 33; k++) begin
      n = 0;
      do begin
        stepCycle();
        n++;
        checks++;
        if (phase_inc !== mPhase || sym_bit !== mBit || sym_strobe !== mStrobe) begin
          errors++;
          $display("[TB] FAIL fsk_model tick %0d got %h/%b/%b want %h/%b/%b",
                   k, phase_inc, sym_bit, sym_strobe, mPhase, mBit, mStrobe);
        end
      end while (sym_strobe !== 1'b1 && n < 2 * DIV);
      checks++;
      if (n != DIV) begin
        errors++;
        $display("[TB] FAIL fsk_spacing tick %0d got %0d cycles want %0d", k, n, DIV);
      end
      if (k <= 5) begin
        checks++;
        if (sym_bit !== expBits[k] || phase_inc !== (expBits[k] ? fb : fa)) begin
          errors++;
          $display("[TB] FAIL fsk_sequence tick %0d got %h/%b want %h/%b",
                   k, phase_inc, sym_bit, expBits[k] ? fb : fa, expBits[k]);
        end
      end
      if (k == 31 || k == 32) begin
        checks++;
        if (sym_bit !== (k == 31)) begin
          errors++;
          $display("[TB] FAIL fsk_period tick %0d got %b want %b", k, sym_bit, k == 31);
        end
      end
    end
  endtask

  task automatic test_sweep();
    int expPh [6] = '{100, 110, 120, 130, 100, 110};
    int n;
    doLoad(2'd2, 32'd100, 32'd130, 32'd10);
    checks++;
    if (phase_inc !== 32'd100) begin
      errors++;
      $display("[TB] FAIL sweep_load got %0d want 100", phase_inc);
    end
    for (int k = 1; k < 6; k++) begin
      n = 0;
      do begin
        stepCycle();
        n++;
      end while (sym_strobe !== 1'b1 && n < 2 * DIV);
      checks++;
      if (sym_strobe !== 1'b1 || phase_inc !== 32'(expPh[k])) begin
        errors++;
        $display("[TB] FAIL sweep_step tick %0d got %0d strobe %b want %0d strobe 1",
                 k, phase_inc, sym_strobe, expPh[k]);
      end
    end
  endtask

  task automatic test_en_gap();
    int edges;
    doLoad(2'd1, $urandom, $urandom, $urandom);
    edges = 0;
    repeat (2) begin stepCycle(); edges++; end
    en = 1'b0;
    repeat (3) begin
      stepCycle();
      edges++;
      checks++;
      if (sym_strobe !== 1'b0 || phase_inc !== mPhase || sym_bit !== 1'b1) begin
        errors++;
        $display("[TB] FAIL en_low_hold got %h/%b/%b want %h/1/0", phase_inc, sym_bit, sym_strobe, mPhase);
      end
    end
    en = 1'b1;
    do begin stepCycle(); edges++; end while (sym_strobe !== 1'b1 && edges < 12);
    checks++;
    if (edges != DIV + 3 || phase_inc !== mPhase || sym_bit !== mBit) begin
      errors++;
      $display("[TB] FAIL en_gap_tick got %0d cycles %h/%b want %0d cycles %h/%b",
               edges, phase_inc, sym_bit, DIV + 3, mPhase, mBit);
    end
  endtask

  task automatic test_load_on_tick();
    logic [31:0] na, nb;
    int n;
    doLoad(2'd2, 32'd1000, 32'd5000, 32'd7);
    n = 0;
    while (mEnCnt % DIV != DIV - 1 && n < 10) begin stepCycle(); n++; end
    na = $urandom; nb = $urandom;
    mode = 2'd1; f0 = na; f1 = nb; load = 1'b1;
    stepCycle();
    load = 1'b0;
    checks++;
    if (sym_strobe !== 1'b0 || phase_inc !== nb || sym_bit !== 1'b1) begin
      errors++;
      $display("[TB] FAIL load_on_tick got %h/%b/%b want %h/1/0", phase_inc, sym_bit, sym_strobe, nb);
    end
    n = 0;
    do begin stepCycle(); n++; end while (sym_strobe !== 1'b1 && n < 12);
    checks++;
    if (n != DIV || phase_inc !== mPhase) begin
      errors++;
      $display("[TB] FAIL load_restart got %0d cycles %h want %0d cycles %h", n, phase_inc, DIV, mPhase);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    doLoad(2'd0, $urandom | 32'h1, $urandom, $urandom);
    repeat (2) stepCycle();
    reset = 1'b1;
    #1;
    modelReset();
    checks++;
    if (phase_inc !== 32'h0 || sym_bit !== 1'b1 || sym_strobe !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_async got %h/%b/%b want 00000000/1/0", phase_inc, sym_bit, sym_strobe);
    end
    stepCycle();
    reset = 1'b0;
    n = 0;
    do begin
      stepCycle();
      n++;
      checks++;
      if (phase_inc !== mPhase || sym_bit !== mBit || sym_strobe !== mStrobe) begin
        errors++;
        $display("[TB] FAIL reset_resume got %h/%b/%b want %h/%b/%b",
                 phase_inc, sym_bit, sym_strobe, mPhase, mBit, mStrobe);
      end
    end while (sym_strobe !== 1'b1 && n < 12);
    checks++;
    if (n != DIV) begin
      errors++;
      $display("[TB] FAIL reset_first_tick got %0d cycles want %0d", n, DIV);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      en   = ($urandom_range(0, 3) != 0);
      load = (i == 0) || ($urandom_range(0, 19) == 0);
      mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        f0 = $urandom; f1 = $urandom; step = $urandom;
      end else begin
        f0 = $urandom_range(0, 1000);
        f1 = f0 + $urandom_range(0, 200);
        step = $urandom_range(0, 60);
      end
      reset = ($urandom_range(0, 149) == 0);
      stepCycle();
      reset = 1'b0;
      checks++;
      if (phase_inc !== mPhase || sym_bit !== mBit || sym_strobe !== mStrobe) begin
        errors++;
        $display("[TB] FAIL random cyc %0d got %h/%b/%b want %h/%b/%b",
                 i, phase_inc, sym_bit, sym_strobe, mPhase, mBit, mStrobe);
      end
    end
    load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; load = 1'b0; mode = 2'd0;
    f0 = '0; f1 = '0; step = '0;
    buildPrbs();
    modelReset();
    test_reset();
    test_const();
    test_fsk();
    test_sweep();
    test_en_gap();
    test_load_on_tick();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod_phase_ctrl.md
# mod_phase_ctrl

Upstream modulation controller for the `waveform_gen` DDS. It produces the 32-bit `phase_inc` tuning word that drives the DDS phase accumulator, in one of three modes: constant tone, LFSR-driven binary FSK, or linear frequency sweep. It also exports the current PRBS symbol bit and a one-cycle symbol strobe, so downstream ASK/BPSK logic stays aligned with frequency changes.

## Interface
- `SYMBOL_DIV`, default 50_000_000: clock cycles per symbol; must be ≥ 2.
- `PW`, default 32: phase-increment width, matches the DDS `phase_inc`.

- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `en`  in  1  advance enable; 0 freezes all state.
- `load`  in  1  single-cycle pulse; latches configuration and restarts.
- `mode`  in  2  0 = CONST, 1 = FSK, 2 = SWEEP, 3 = treated as CONST.
- `f0_inc`  in  PW  base tuning word (FSK bit 0, sweep start).
- `f1_inc`  in  PW  FSK bit-1 word, or sweep upper limit.
- `sweep_step`  in  PW  per-symbol sweep increment.
- `phase_inc`  out  PW  tuning word to the DDS; registered.
- `sym_bit`  out  1  current PRBS bit (`lfsr[0]`); registered.
- `sym_strobe`  out  1  one-cycle pulse at each symbol boundary.

## Operation
- Configuration shadow registers: `mode_r`, `f0_r`, `f1_r`, `step_r`. They capture their inputs only on `load`; the live inputs are otherwise ignored.
- Symbol timer `cnt`, range 0..SYMBOL_DIV-1. A tick is the edge where `en` = 1 and `cnt` = SYMBOL_DIV-1.
- LFSR: 5 bits, seed 5'b00001, `next = {lfsr[0]^lfsr[2], lfsr[4:1]}`, period 31. It advances only on a tick.
- Sweep accumulator `acc`: on each tick, if the 33-bit sum `acc + step_r` > `f1_r` (unsigned), then `acc` ← `f0_r`; otherwise `acc` ← the sum. `acc` = `f1_r` is a legal value.
- `phase_inc` source by mode:
  - CONST: `f0_r`.
  - FSK: `next_bit ? f1_r : f0_r`.
  - SWEEP: next `acc`.
- Effect of `load` on the next edge:
  - Shadow registers ← inputs.
  - `cnt` ← 0, `lfsr` ← seed, `acc` ← `f0_inc`.
  - `phase_inc` ← its value under the new mode with seed bit 1 (FSK gives `f1_inc`; CONST and SWEEP give `f0_inc`).
  - `sym_strobe` ← 0.
- `load` has priority over a tick in the same cycle. `load` acts regardless of `en`.
- `en` = 0: `cnt`, `lfsr`, `acc` and `phase_inc` hold; `sym_strobe` = 0.
- Reset values (asynchronous, immediate):
  - Outputs: `phase_inc` = 0, `sym_bit` = 1, `sym_strobe` = 0.
  - Internal: `cnt` = 0, `lfsr` = seed, `acc` = 0, all shadow registers = 0, `mode_r` = CONST.
- Reset asserted mid-symbol discards the partial count. After release, the first tick occurs SYMBOL_DIV enabled cycles later.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- On the tick edge, `phase_inc`, `sym_bit` and `sym_strobe` all update together. `sym_strobe` is high for exactly the one following cycle.
- Tick spacing: exactly SYMBOL_DIV enabled cycles. Cycles with `en` low stretch the spacing one-for-one.
- `load` latency: new `phase_inc` is visible 1 cycle after the `load` edge. The first tick follows SYMBOL_DIV enabled cycles after that edge.
- DDS frequency-switch latency is the `waveform_gen` pipeline delay plus 1 cycle.

## Structure
- Shared package `mod_pkg` holds:
  - `typedef enum logic [1:0] {M_CONST, M_FSK, M_SWEEP, M_RSVD} mod_mode_t`
  - `LFSR_SEED = 5'b00001`
  - `LFSR_W = 5`
- One sub-module, `lfsr5` (clk, reset, step, clear, q[4:0]), instantiated once.
- Symbol timer, sweep accumulator and output registers stay in the top level.

## Test plan
Unless stated otherwise, SYMBOL_DIV = 4.
- Reset, then release -> `phase_inc` = 0, `sym_bit` = 1, `sym_strobe` = 0; no strobe before `load`.
- CONST: `load` with `f0_inc` = 32'h045A1CAC, `en` = 1 -> `phase_inc` = 32'h045A1CAC one cycle later; `sym_strobe` pulses every 4 cycles; `phase_inc` never changes.
- FSK: `load` with f0 = 32'h045A1CAC, f1 = 32'h08B43958 -> `sym_bit` per tick = 1,0,0,0,0,1; `phase_inc` = f1,f0,f0,f0,f0,f1, changing together with the strobe; the sequence repeats after 31 ticks.
- SWEEP: `load` with f0 = 100, f1 = 130, step = 10 -> `phase_inc` = 100, then per tick 110, 120, 130, 100, 110.
- `en` low for 3 cycles mid-symbol -> tick delayed by exactly 3 cycles; outputs hold; no strobe while low.
- `load` coincident with a tick, and `reset` asserted mid-symbol -> restart with seed; no strobe that cycle; next strobe exactly 4 enabled cycles later; reset forces `phase_inc` = 0 immediately.
